// File: rtl/vga_band_display.sv
// vga_band_display: 640x480 VGA timing generator for the MiniAlu display stage.
// The visible frame is split into four horizontal bands, each painted from a
// colour register written by the ALU.
// Optional build macro VGA_FRAME_SYNC_WRITE_EN: colour writes land in shadow
// registers and are committed to the active bands on entry to vertical blanking.
module vga_band_display #(
    parameter int unsigned H_VISIBLE = 640,
    parameter int unsigned H_FRONT   = 16,
    parameter int unsigned H_SYNC    = 96,
    parameter int unsigned H_BACK    = 48,
    parameter int unsigned V_VISIBLE = 480,
    parameter int unsigned V_FRONT   = 10,
    parameter int unsigned V_SYNC    = 2,
    parameter int unsigned V_BACK    = 33,
    parameter int unsigned CLK_DIV   = 2
) (
    input  logic       Clock,
    input  logic       Reset,
    input  logic       iColorWriteEnable,
    input  logic [1:0] iColorAddr,
    input  logic [2:0] iColorData,
    output logic       oVGA_R,
    output logic       oVGA_G,
    output logic       oVGA_B,
    output logic       oHSync,
    output logic       oVSync,
    output logic [9:0] oRow,
    output logic [9:0] oCol,
    output logic       oVisible
);

    localparam int unsigned H_TOTAL = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
    localparam int unsigned V_TOTAL = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;
    localparam int unsigned BandH   = V_VISIBLE / 4;
    localparam int unsigned DivW    = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

    localparam logic [DivW-1:0] DivLast = DivW'(CLK_DIV - 1);
    localparam logic [9:0] ColLast        = 10'(H_TOTAL - 1);
    localparam logic [9:0] RowLast        = 10'(V_TOTAL - 1);
    localparam logic [9:0] ColVisEnd      = 10'(H_VISIBLE);
    localparam logic [9:0] RowVisEnd      = 10'(V_VISIBLE);
    localparam logic [9:0] RowLastVisible = 10'(V_VISIBLE - 1);
    localparam logic [9:0] HSyncStart     = 10'(H_VISIBLE + H_FRONT);
    localparam logic [9:0] HSyncEnd       = 10'(H_VISIBLE + H_FRONT + H_SYNC - 1);
    localparam logic [9:0] VSyncStart     = 10'(V_VISIBLE + V_FRONT);
    localparam logic [9:0] VSyncEnd       = 10'(V_VISIBLE + V_FRONT + V_SYNC - 1);
    localparam logic [9:0] Band1Start     = 10'(BandH);
    localparam logic [9:0] Band2Start     = 10'(2 * BandH);
    localparam logic [9:0] Band3Start     = 10'(3 * BandH);

    logic [DivW-1:0] divCnt;
    logic            pixelTick;
    logic            colWrap;
    logic            hSyncActive;
    logic            vSyncActive;
    logic [1:0]      band;
    logic [2:0]      pixelColor;
    logic [2:0]      rgbQ;
    logic [2:0]      bandColor [4];

    // With CLK_DIV=1 the divider stays at 0 and every clock is a tick
    assign pixelTick   = (divCnt == DivLast);
    assign colWrap     = (oCol == ColLast);
    assign oVisible    = (oCol < ColVisEnd) && (oRow < RowVisEnd);
    assign hSyncActive = (oCol >= HSyncStart) && (oCol <= HSyncEnd);
    assign vSyncActive = (oRow >= VSyncStart) && (oRow <= VSyncEnd);

    assign {oVGA_R, oVGA_G, oVGA_B} = rgbQ;

    // Band index from row by threshold compares (no divider)
    always_comb begin
        band = 2'd3;
        if (oRow < Band1Start) begin
            band = 2'd0;
        end else if (oRow < Band2Start) begin
            band = 2'd1;
        end else if (oRow < Band3Start) begin
            band = 2'd2;
        end
    end

    // Colour for the current position; black outside the visible region
    always_comb begin
        pixelColor = 3'b000;
        if (oVisible) begin
            pixelColor = bandColor[band];
        end
    end

    // Pixel-clock divider: tick on the last count, then wrap
    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            divCnt <= '0;
        end else if (pixelTick) begin
            divCnt <= '0;
        end else begin
            divCnt <= divCnt + 1'b1;
        end
    end

    // Column/row counters advance once per pixel tick
    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            oCol <= '0;
            oRow <= '0;
        end else if (pixelTick) begin
            if (colWrap) begin
                oCol <= '0;
                oRow <= (oRow == RowLast) ? 10'd0 : oRow + 10'd1;
            end else begin
                oCol <= oCol + 10'd1;
            end
        end
    end

    // Sync and RGB sampled from pre-increment counters, one tick behind them
    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            oHSync <= 1'b1;
            oVSync <= 1'b1;
            rgbQ   <= 3'b000;
        end else if (pixelTick) begin
            oHSync <= ~hSyncActive;
            oVSync <= ~vSyncActive;
            rgbQ   <= pixelColor;
        end
    end

`ifdef VGA_FRAME_SYNC_WRITE_EN
    logic [2:0] shadowColor [4];
    logic       commitTick;

    // Row goes from last visible line into vertical blanking on this tick
    assign commitTick = pixelTick && colWrap && (oRow == RowLastVisible);

    // Writes land in shadows; the active bands reload only at blanking entry
    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            for (int i = 0; i < 4; i++) begin
                shadowColor[i] <= 3'b000;
                bandColor[i]   <= 3'b000;
            end
        end else begin
            if (iColorWriteEnable) begin
                shadowColor[iColorAddr] <= iColorData;
            end
            // Non-blocking read: a write on this edge commits next frame
            if (commitTick) begin
                for (int i = 0; i < 4; i++) begin
                    bandColor[i] <= shadowColor[i];
                end
            end
        end
    end
`else
    // Writes update the active band immediately, even mid-frame
    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            for (int i = 0; i < 4; i++) begin
                bandColor[i] <= 3'b000;
            end
        end else if (iColorWriteEnable) begin
            bandColor[iColorAddr] <= iColorData;
        end
    end
`endif

endmodule

// File: tb/tb_vga_band_display.sv
// tb_vga_band_display: randomized self-checking bench for vga_band_display, run on a
// reduced screen geometry so several whole frames fit in a short simulation.
module tb_vga_band_display;

    localparam int HV = 20;
    localparam int HF = 4;
    localparam int HS = 6;
    localparam int HB = 4;
    localparam int VV = 16;
    localparam int VF = 2;
    localparam int VS = 2;
    localparam int VB = 3;
    localparam int CD = 2;
    localparam int HT = HV + HF + HS + HB;
    localparam int VT = VV + VF + VS + VB;
    localparam int FRAME = HT * VT;
    localparam int FRAME_CLK = FRAME * CD;
    localparam int BH = VV / 4;

    logic       Clock = 1'b0;
    logic       Reset = 1'b1;
    logic       we = 1'b0;
    logic [1:0] addr = 2'd0;
    logic [2:0] data = 3'd0;
    logic       oVGA_R, oVGA_G, oVGA_B, oHSync, oVSync, oVisible;
    logic [9:0] oRow, oCol;
    logic [2:0] rgb;

    int nChecks = 0;
    int nFails = 0;

    vga_band_display #(
        .H_VISIBLE(HV), .H_FRONT(HF), .H_SYNC(HS), .H_BACK(HB),
        .V_VISIBLE(VV), .V_FRONT(VF), .V_SYNC(VS), .V_BACK(VB),
        .CLK_DIV(CD)
    ) dut (
        .Clock(Clock),
        .Reset(Reset),
        .iColorWriteEnable(we),
        .iColorAddr(addr),
        .iColorData(data),
        .oVGA_R(oVGA_R),
        .oVGA_G(oVGA_G),
        .oVGA_B(oVGA_B),
        .oHSync(oHSync),
        .oVSync(oVSync),
        .oRow(oRow),
        .oCol(oCol),
        .oVisible(oVisible)
    );

    always #5 Clock = ~Clock;

    assign rgb = {oVGA_R, oVGA_G, oVGA_B};

    // Reference model: linear pixel index into the frame plus edge count since reset
    int         mN, mPos, mRow, mCol;
    bit         mTick;
    logic       mHs, mVs;
    logic [2:0] mRgb;
    logic [2:0] mColor [4];
    logic [2:0] mShadow [4];

    assign mRow  = mPos / HT;
    assign mCol  = mPos % HT;
    assign mTick = ((mN + 1) % CD) == 0;

    always @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            mN   <= 0;
            mPos <= 0;
            mHs  <= 1'b1;
            mVs  <= 1'b1;
            mRgb <= 3'b000;
            for (int i = 0; i < 4; i++) begin
                mColor[i]  <= 3'b000;
                mShadow[i] <= 3'b000;
            end
        end else begin
            mN <= mN + 1;
            if (mTick) begin
                mHs  <= !(mCol >= HV + HF && mCol < HV + HF + HS);
                mVs  <= !(mRow >= VV + VF && mRow < VV + VF + VS);
                mRgb <= (mCol < HV && mRow < VV) ? mColor[mRow / BH] : 3'b000;
                mPos <= (mPos + 1) % FRAME;
            end
`ifdef VGA_FRAME_SYNC_WRITE_EN
            if (we) mShadow[addr] <= data;
            if (mTick && mPos == VV * HT - 1) begin
                for (int i = 0; i < 4; i++) mColor[i] <= mShadow[i];
            end
`else
            if (we) mColor[addr] <= data;
`endif
        end
    end

    logic [25:0] dutVec, modVec;
    assign dutVec = {oRow, oCol, oHSync, oVSync, rgb, oVisible};
    assign modVec = {10'(mRow), 10'(mCol), mHs, mVs, mRgb, (mCol < HV) && (mRow < VV)};

    // Stimulus helpers (no checking inside)
    task automatic doWrite(input logic [1:0] a, input logic [2:0] d);
        addr = a;
        data = d;
        we   = 1'b1;
        @(negedge Clock);
        we   = 1'b0;
    endtask

    task automatic waitPos(input int r, input int c, output bit found);
        found = 1'b0;
        repeat (CD) @(negedge Clock);
        for (int i = 0; i < 2 * FRAME_CLK && !found; i++) begin
            if (oRow == 10'(r) && oCol == 10'(c)) found = 1'b1;
            else @(negedge Clock);
        end
    endtask

    task automatic test_reset();
        Reset = 1'b1;
        repeat (3) @(negedge Clock);
        nChecks++;
        if (oRow !== 10'd0 || oCol !== 10'd0) begin
            nFails++;
            $display("FAIL reset_counters: row=%0d col=%0d, required 0 0", oRow, oCol);
        end
        nChecks++;
        if ({oHSync, oVSync, rgb, oVisible} !== 6'b110001) begin
            nFails++;
            $display("FAIL reset_outputs: hs,vs,rgb,vis=%b, required 110001",
                     {oHSync, oVSync, rgb, oVisible});
        end
        Reset = 1'b0;
    endtask

    task automatic test_timing();
        int hLow = 0, vLow = 0;
        bit seenWrap = 1'b0;
        logic prevHs = 1'b1, prevVs = 1'b1;
        logic [9:0] prevRow = 10'd0;
        for (int i = 0; i < 2 * FRAME_CLK; i++) begin
            @(negedge Clock);
            nChecks++;
            if (dutVec !== modVec) begin
                nFails++;
                $display("FAIL timing: dut=%h model=%h t=%0t", dutVec, modVec, $time);
            end
            if (i < FRAME_CLK) begin
                if (!oHSync) hLow++;
                if (!oVSync) vLow++;
            end
            if (prevHs && !oHSync) begin
                nChecks++;
                if (oCol !== 10'(HV + HF + 1)) begin
                    nFails++;
                    $display("FAIL hsync_fall_col: col=%0d, required %0d", oCol, HV + HF + 1);
                end
            end
            if (prevVs && !oVSync) begin
                nChecks++;
                if (oRow !== 10'(VV + VF) || oCol !== 10'd1) begin
                    nFails++;
                    $display("FAIL vsync_fall_pos: row=%0d col=%0d, required %0d 1",
                             oRow, oCol, VV + VF);
                end
            end
            if (prevRow == 10'(VT - 1) && oRow == 10'd0) seenWrap = 1'b1;
            prevHs  = oHSync;
            prevVs  = oVSync;
            prevRow = oRow;
        end
        nChecks++;
        if (hLow != VT * HS * CD) begin
            nFails++;
            $display("FAIL hsync_low_clocks: got %0d, required %0d", hLow, VT * HS * CD);
        end
        nChecks++;
        if (vLow != VS * HT * CD) begin
            nFails++;
            $display("FAIL vsync_low_clocks: got %0d, required %0d", vLow, VS * HT * CD);
        end
        nChecks++;
        if (!seenWrap) begin
            nFails++;
            $display("FAIL row_wrap: seen=%0b, required 1", seenWrap);
        end
    endtask

    task automatic test_bands();
        int         pr [6] = '{1, 5, 9, 14, 2, VV + 2};
        int         pc [6] = '{5, 5, 5, 5, HV + 1, 5};
        logic [2:0] pe [6] = '{3'b100, 3'b010, 3'b001, 3'b111, 3'b000, 3'b000};
        bit found;
        @(negedge Clock);
        doWrite(2'd0, 3'b100);
        doWrite(2'd1, 3'b010);
        doWrite(2'd2, 3'b001);
        doWrite(2'd3, 3'b111);
        for (int i = 0; i < 2 * FRAME_CLK; i++) begin
            @(negedge Clock);
            nChecks++;
            if (dutVec !== modVec) begin
                nFails++;
                $display("FAIL bands_run: dut=%h model=%h t=%0t", dutVec, modVec, $time);
            end
        end
        for (int k = 0; k < 6; k++) begin
            waitPos(pr[k], pc[k] + 1, found);
            nChecks++;
            if (!found || rgb !== pe[k]) begin
                nFails++;
                $display("FAIL bands_pixel(%0d,%0d): found=%0b rgb=%b, required %b",
                         pr[k], pc[k], found, rgb, pe[k]);
            end
        end
    endtask

    task automatic test_random_writes();
        for (int i = 0; i < 2 * FRAME_CLK; i++) begin
            @(negedge Clock);
            nChecks++;
            if (dutVec !== modVec) begin
                nFails++;
                $display("FAIL random_writes: dut=%h model=%h t=%0t", dutVec, modVec, $time);
            end
            we   = ($urandom_range(0, 3) == 0);
            addr = 2'($urandom_range(0, 3));
            data = 3'($urandom_range(0, 7));
        end
        we = 1'b0;
    endtask

    task automatic test_back_to_back();
        bit found;
        @(negedge Clock);
        doWrite(2'd0, 3'b011);
        doWrite(2'd0, 3'b101);
        for (int i = 0; i < 2 * FRAME_CLK; i++) begin
            @(negedge Clock);
            nChecks++;
            if (dutVec !== modVec) begin
                nFails++;
                $display("FAIL back_to_back_run: dut=%h model=%h t=%0t", dutVec, modVec, $time);
            end
        end
        waitPos(1, 4, found);
        nChecks++;
        if (!found || rgb !== 3'b101) begin
            nFails++;
            $display("FAIL back_to_back_last_wins: found=%0b rgb=%b, required 101", found, rgb);
        end
    endtask

    task automatic test_frame_sync();
        int         pr [3] = '{6, 7, 5};
        logic [2:0] pe [3];
        bit found;
`ifdef VGA_FRAME_SYNC_WRITE_EN
        pe = '{3'b001, 3'b001, 3'b110};
`else
        pe = '{3'b110, 3'b110, 3'b110};
`endif
        @(negedge Clock);
        doWrite(2'd1, 3'b001);
        repeat (2 * FRAME_CLK) @(negedge Clock);
        waitPos(5, 3, found);
        nChecks++;
        if (!found) begin
            nFails++;
            $display("FAIL frame_sync_wait: found=%0b, required 1", found);
        end
        doWrite(2'd1, 3'b110);
        for (int k = 0; k < 3; k++) begin
            waitPos(pr[k], 6, found);
            nChecks++;
            if (!found || rgb !== pe[k] || dutVec !== modVec) begin
                nFails++;
                $display("FAIL frame_sync_pixel(%0d,5): found=%0b rgb=%b, required %b",
                         pr[k], found, rgb, pe[k]);
            end
        end
    endtask

    task automatic test_commit_coincident();
        logic [2:0] pe [2];
        bit found = 1'b0;
`ifdef VGA_FRAME_SYNC_WRITE_EN
        pe = '{3'b010, 3'b101};
`else
        pe = '{3'b101, 3'b101};
`endif
        @(negedge Clock);
        doWrite(2'd2, 3'b010);
        repeat (2 * FRAME_CLK) @(negedge Clock);
        for (int i = 0; i < 2 * FRAME_CLK && !found; i++) begin
            @(negedge Clock);
            if (oRow == 10'(VV - 1) && oCol == 10'(HT - 1) && mTick) found = 1'b1;
        end
        nChecks++;
        if (!found) begin
            nFails++;
            $display("FAIL commit_edge_wait: found=%0b, required 1", found);
        end
        doWrite(2'd2, 3'b101);
        for (int k = 0; k < 2; k++) begin
            waitPos(9, 6, found);
            nChecks++;
            if (!found || rgb !== pe[k] || dutVec !== modVec) begin
                nFails++;
                $display("FAIL commit_coincident_frame%0d: found=%0b rgb=%b, required %b",
                         k + 1, found, rgb, pe[k]);
            end
        end
    endtask

    task automatic test_midframe_reset();
        int pr [4] = '{1, 5, 9, 14};
        bit found;
        @(negedge Clock);
        doWrite(2'd1, 3'b110);
        doWrite(2'd3, 3'b111);
        repeat (2 * FRAME_CLK) @(negedge Clock);
        waitPos(10, 15, found);
        nChecks++;
        if (!found) begin
            nFails++;
            $display("FAIL reset_mid_wait: found=%0b, required 1", found);
        end
        #2 Reset = 1'b1;
        #1;
        nChecks++;
        if ({oRow, oCol, oHSync, oVSync, rgb, oVisible} !== {20'd0, 6'b110001}) begin
            nFails++;
            $display("FAIL reset_mid_outputs: row=%0d col=%0d hs,vs,rgb,vis=%b, required 0 0 110001",
                     oRow, oCol, {oHSync, oVSync, rgb, oVisible});
        end
        @(negedge Clock);
        Reset = 1'b0;
        for (int k = 0; k < 4; k++) begin
            waitPos(pr[k], 6, found);
            nChecks++;
            if (!found || rgb !== 3'b000 || dutVec !== modVec) begin
                nFails++;
                $display("FAIL reset_mid_band%0d: found=%0b rgb=%b, required 000", k, found, rgb);
            end
        end
    endtask

    initial begin
        test_reset();
        test_timing();
        test_bands();
        test_random_writes();
        test_back_to_back();
        test_frame_sync();
        test_commit_coincident();
        test_midframe_reset();
        $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
        $finish;
    end

    initial begin
        #1500000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/vga_band_display.md
Name: vga_band_display

Overview:
- Downstream display stage for the MiniAlu core.
- Consumes colour writes issued by the ALU when it executes band-write instructions.
- Generates 640x480 VGA timing (hsync, vsync, row/column counters).
- Drives 3-bit RGB: the visible frame is split into four horizontal bands, each painted from one programmable colour register.

Parameters:
H_VISIBLE, 640, visible pixels per line
H_FRONT, 16, horizontal front porch (pixels)
H_SYNC, 96, hsync pulse width (pixels)
H_BACK, 48, horizontal back porch (pixels)
V_VISIBLE, 480, visible lines per frame
V_FRONT, 10, vertical front porch (lines)
V_SYNC, 2, vsync pulse width (lines)
V_BACK, 33, vertical back porch (lines)
CLK_DIV, 2, system clocks per pixel (>=1)

Ports:
Clock  in  1  system clock, rising edge
Reset  in  1  asynchronous, active-high reset
iColorWriteEnable  in  1  write strobe from ALU, one cycle per write
iColorAddr  in  2  band index 0..3
iColorData  in  3  {R,G,B} colour for the band
oVGA_R  out  1  red
oVGA_G  out  1  green
oVGA_B  out  1  blue
oHSync  out  1  horizontal sync, active low
oVSync  out  1  vertical sync, active low
oRow  out  10  current line counter
oCol  out  10  current pixel counter
oVisible  out  1  high while the current counters are in the visible region

Behaviour:
- Reset (async assert, deassert sampled on Clock):
  - divider, oRow and oCol = 0
  - oHSync = oVSync = 1
  - RGB = 0
  - all four band registers = 0
  - oVisible = 1 (row 0, col 0 is visible)
- Pixel tick:
  - Divider counts 0..CLK_DIV-1; tick asserts when divider = CLK_DIV-1, then divider wraps to 0.
  - CLK_DIV=1 means tick every clock.
- Counters (advance only on tick):
  - H_TOTAL = sum of H params (800); V_TOTAL = sum of V params (525).
  - oCol increments and wraps H_TOTAL-1 -> 0.
  - On column wrap, oRow increments and wraps V_TOTAL-1 -> 0.
- Sync and colour timing:
  - Sync and RGB are registered on tick from the pre-increment counter values, so they lag oRow/oCol by exactly one pixel tick.
  - hsync low for col in [H_VISIBLE+H_FRONT, H_VISIBLE+H_FRONT+H_SYNC-1] = [656,751].
  - vsync low for row in [V_VISIBLE+V_FRONT, V_VISIBLE+V_FRONT+V_SYNC-1] = [490,491].
  - oVisible is combinational: col<H_VISIBLE && row<V_VISIBLE.
  - RGB = 0 whenever the sampled position is not visible.
- Band selection:
  - band = row / (V_VISIBLE/4); with defaults, band height is 120 lines.
  - Rows 0-119 -> band 0, 120-239 -> band 1, 240-359 -> band 2, 360-479 -> band 3.
  - Implement with comparators, not a divider.
- Colour writes:
  - On iColorWriteEnable, register[iColorAddr] <= iColorData at that clock edge.
  - Writes are accepted every clock, independent of tick. There is no back-pressure.
  - Two writes to the same band in consecutive cycles: last write wins.
- Reset mid-frame: everything returns to reset values immediately; timing restarts at row 0, col 0.

Optional Feature:
Macro: VGA_FRAME_SYNC_WRITE_EN
- Defined:
  - Writes land in four shadow registers.
  - Active band registers load from the shadows on the tick where row goes V_VISIBLE-1 -> V_VISIBLE (entry to vertical blanking), giving tear-free updates.
  - If a write coincides with that commit edge, the commit uses the pre-write shadow contents; the new value commits at the next frame.
  - Reset clears both shadow and active registers.
- Undefined:
  - No shadow registers.
  - Writes take effect at the next clock edge, mid-frame if issued during the visible region.

Test Plan:
- Release reset, CLK_DIV=2 -> oHSync falls at col 656, 1312 clocks after first tick alignment; stays low 96 ticks (192 clocks); line period 1600 clocks.
- Run one full frame -> oVSync low only during rows 490-491 (2 x 1600 clocks); frame period 840000 clocks; oRow wraps 524 -> 0.
- Write band0=3'b100, band1=3'b010, band2=3'b001, band3=3'b111 -> sampled RGB at (row 10, col 5) = 100, (row 130) = 010, (row 250) = 001, (row 470) = 111. RGB = 000 at col 640-799 and at rows 480-524.
- Assert Reset at row 200, col 300 -> next sampled outputs: counters 0, sync=1, RGB=0, all bands 0.
- With VGA_FRAME_SYNC_WRITE_EN, write band1=3'b110 at row 150 -> RGB stays old value through row 239; 110 appears from row 120 of the next frame. Without the macro, 110 appears on the pixel sampled one tick after the write.
- Write coincident with the row 479 -> 480 commit tick (macro defined) -> value is not visible in the next frame; it is visible in the frame after.
